// File: rtl/seq_match_scheduler.sv
// Round-robin scheduler sharing one programmable bit-pattern matcher across NCH serial channels.
// Optional per-channel saturating match counters are built when SEQ_MATCH_CNT_EN is defined.
module seq_match_scheduler #(
  parameter int NCH = 4,
  parameter int PW  = 8,
  parameter int CW  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [NCH-1:0]            ch_valid,
  input  logic [NCH-1:0]            ch_din,
  output logic [NCH-1:0]            ch_ready,
  input  logic                      cfg_we,
  input  logic [PW-1:0]             cfg_pattern,
  input  logic [$clog2(PW+1)-1:0]   cfg_len,
  input  logic                      cfg_overlap,
  output logic                      cfg_err,
  output logic                      match_valid,
  output logic [$clog2(NCH)-1:0]    match_ch
`ifdef SEQ_MATCH_CNT_EN
  ,
  input  logic [$clog2(NCH)-1:0]    cnt_sel,
  output logic [CW-1:0]             cnt_data
`endif
);

  localparam int CHW = $clog2(NCH);
  localparam int LW  = $clog2(PW + 1);

  if (NCH < 2 || NCH > 16 || PW < 2 || CW < 1) begin : g_bad_param
    $error("seq_match_scheduler: parameter out of range");
  end

  logic [CHW-1:0] ptr;
  logic [PW-1:0]  pat;
  logic [LW-1:0]  len;
  logic           ovl;
  logic [PW-1:0]  hist [NCH];
  logic [LW-1:0]  fill [NCH];

  logic           found;
  logic [CHW-1:0] cand;
  logic [CHW-1:0] g_idx;
  logic           xfer;
  logic           accept;
  logic [PW-1:0]  mask;
  logic [PW-1:0]  hist_nx;
  logic [LW-1:0]  fill_nx;
  logic           hit;

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    found    = 1'b0;
    cand     = '0;
    g_idx    = '0;
    ch_ready = '0;
    for (int k = 1; k <= NCH; k++) begin
      cand = CHW'((int'(ptr) + k) % NCH);
      if (!found && ch_valid[cand]) begin
        found = 1'b1;
        g_idx = cand;
      end
    end
    if (enable && found) ch_ready[g_idx] = 1'b1;
  end

  always_comb begin
    mask = '0;
    for (int b = 0; b < PW; b++) mask[b] = (b < int'(len));
  end

  assign xfer    = enable && found;
  assign accept  = cfg_we && !enable && (cfg_len != '0) && (int'(cfg_len) <= PW);
  assign hist_nx = {hist[g_idx][PW-2:0], ch_din[g_idx]};
  assign fill_nx = (fill[g_idx] < len) ? fill[g_idx] + LW'(1) : len;
  assign hit     = xfer && (fill_nx >= len) && ((hist_nx & mask) == (pat & mask));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  // NOTE: histories and fill counts are small flop arrays that must reset, unlike a RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= CHW'(NCH - 1);
      pat         <= '0;
      len         <= LW'(1);
      ovl         <= 1'b0;
      cfg_err     <= 1'b0;
      match_valid <= 1'b0;
      match_ch    <= '0;
      for (int i = 0; i < NCH; i++) begin
        hist[i] <= '0;
        fill[i] <= '0;
      end
    end else begin
      cfg_err     <= cfg_we && !accept;
      match_valid <= hit;
      if (hit) match_ch <= g_idx;
      if (accept) begin
        pat <= cfg_pattern;
        len <= cfg_len;
        ovl <= cfg_overlap;
        ptr <= CHW'(NCH - 1);
        for (int i = 0; i < NCH; i++) begin
          hist[i] <= '0;
          fill[i] <= '0;
        end
      end else if (xfer) begin
        ptr         <= g_idx;
        hist[g_idx] <= hist_nx;
        // Non-overlapping mode restarts the count so the next match needs len fresh bits.
        fill[g_idx] <= (hit && !ovl) ? '0 : fill_nx;
      end
    end
  end

`ifdef SEQ_MATCH_CNT_EN
  logic [CW-1:0] cnt [NCH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < NCH; i++) cnt[i] <= '0;
    end else if (hit && cnt[g_idx] != '1) begin
      cnt[g_idx] <= cnt[g_idx] + CW'(1);
    end
  end

  assign cnt_data = (int'(cnt_sel) < NCH) ? cnt[cnt_sel] : '0;
`endif

endmodule

// File: doc/seq_match_scheduler.md
Name: seq_match_scheduler

Overview:
- Shares one programmable bit-pattern match engine among NCH serial input channels.
- A round-robin scheduler grants at most one channel per cycle and stores each channel's bit history locally; the single shared comparator checks the granted channel against the configured pattern.
- Configuration covers pattern, length and overlap/non-overlap mode, and sits between the serial front-ends and the match/event logic.

Parameters:
- NCH, 4, number of serial channels (2..16).
- PW, 8, maximum pattern length in bits.
- CW, 16, width of the optional per-channel match counters.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- enable  input  1  1 = scheduling and matching active; 0 = all ch_ready low.
- ch_valid  input  NCH  per-channel bit valid.
- ch_din  input  NCH  per-channel serial data bit.
- ch_ready  output  NCH  one-hot grant; a bit transfers when ch_valid[i]&ch_ready[i].
- cfg_we  input  1  configuration write strobe.
- cfg_pattern  input  PW  pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  input  $clog2(PW+1)  pattern length, legal range 1..PW.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_err  output  1  one-cycle pulse when a configuration write is rejected.
- match_valid  output  1  one-cycle pulse on a detected match.
- match_ch  output  $clog2(NCH)  channel of the current match; holds its value between pulses.

Behaviour:
- Reset values: ch_ready=0, cfg_err=0, match_valid=0, match_ch=0, rr pointer=NCH-1, all histories and fill counts=0, pattern=0, len=1, overlap=0.
- Scheduling:
  - ch_ready is combinational from ch_valid, enable and the rr pointer.
  - The grant goes to the first valid channel searching upward from pointer+1, wrapping modulo NCH.
  - At most one bit of ch_ready is set. ch_ready=0 when enable=0 or no channel is valid.
  - On a transfer the pointer updates to the granted index. Otherwise it holds.
  - Requesters must not make ch_valid depend on ch_ready.
- Per-channel state:
  - hist[i] is a PW-bit shift register: on a transfer, hist <= {hist[PW-2:0], din}.
  - fill[i] counts received bits, saturating at len.
- Match condition, evaluated in the transfer cycle on the next values: fill_next>=len and the low len bits of hist_next equal the low len bits of the pattern.
- Match output:
  - match_valid is registered and asserts on the cycle after the transfer, with match_ch = the granted index.
  - Latency is 1 clock.
- Non-overlap: on a match, fill[i] is cleared to 0, so the next match needs len fresh bits.
- Overlap: fill[i] is kept, so the next bit may complete another match.
- Idle channels keep their state indefinitely; there is no timeout.
- Config write:
  - Accepted only when enable=0 and 1<=cfg_len<=PW.
  - On acceptance: latch pattern/len/overlap and clear every hist, fill and the rr pointer to their reset values.
  - Otherwise: ignore the write and pulse cfg_err on the next cycle.
- If enable and cfg_we are both high in the same cycle, the write is rejected and traffic proceeds.
- Deasserting enable freezes all state. Reasserting it resumes from the frozen state.
- Asserting rst mid-stream clears everything immediately, including a pending match_valid.

Optional Feature:
- Macro: SEQ_MATCH_CNT_EN.
- When defined:
  - Per-channel CW-bit saturating match counters increment on each match and clear on an accepted config write or rst.
  - Adds ports cnt_sel (input, $clog2(NCH)) and cnt_data (output, CW), where cnt_data = counter[cnt_sel] combinationally.
  - A counter at all-ones stays at all-ones.
- When undefined: no counters and no extra ports; all other behaviour is identical.

Test Plan:
- Config pattern=4'b1010, len=4, overlap=0, then enable. Channel 0 alone sends 1,0,1,0,1,0 -> exactly one match_valid, 1 cycle after the 4th bit, match_ch=0.
- Same config with overlap=1, channel 0 sends 1,0,1,0,1,0 -> match_valid after bits 4 and 6.
- All 4 channels hold ch_valid=1 continuously from reset -> ch_ready sequence 0001,0010,0100,1000,0001. Each channel, fed 1010, matches on its own 4th grant with the correct match_ch.
- Channel 1 sends 1,0 then drops valid while channel 2 runs for 10 cycles; channel 1 then sends 1,0 -> match on channel 1, showing per-channel history is preserved.
- cfg_we with enable=1, or with cfg_len=0 -> cfg_err pulses 1 cycle and the pattern is unchanged. Assert rst between bits 3 and 4 of 1010 -> no match after bit 4.
- With SEQ_MATCH_CNT_EN, CW=2: four matches on channel 3 -> cnt_data=3 with cnt_sel=3, saturated.
